alu_decode: RTL and testbench

Single-stage decode/operand-fetch block that produces the operand and function inputs consumed by the `arithmetic` ALU. It accepts RV32I OP (0x33) and OP-IMM (0x13) instruction words over a valid/ready handshake, reads sources from an internal 32×32 register file, and forms `lhs`/`rhs`/`operation`/`metadata`/`rd`. It registers them on a valid/ready output port. Write-back from downstream enters through a dedicated write port.

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/alu_decode_register_file.sv | 53 +++++
 rtl/alu_decode.sv | 165 ++++++++++++++++
 tb/tb_alu_decode.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants and the decoded-operand bundle type.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        F3_ADD  = 3'd0,
        F3_SLL  = 3'd1,
        F3_SLT  = 3'd2,
        F3_SLTU = 3'd3,
        F3_XOR  = 3'd4,
        F3_SR   = 3'd5,
        F3_OR   = 3'd6,
        F3_AND  = 3'd7
    } funct3_e;

    // Everything the ALU stage consumes, held in one pipeline register.
    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] lhs;
        logic [XLEN-1:0] rhs;
        logic [2:0]      operation;
        logic [6:0]      metadata;
        logic [4:0]      rd;
    } decode_bundle_t;

endpackage

// File: rtl/alu_decode_register_file.sv
// 2-read/1-write architectural register file; x0 always reads zero.
module register_file
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         rs1_addr,
    input  logic [AW-1:0]         rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];

    // Synchronous clear of the whole array; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we && (waddr != {AW{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port 1, forcing zero for x0 regardless of array contents.
    always_comb begin
        rs1_data = {DATA_WIDTH{1'b0}};
        if (rs1_addr != {AW{1'b0}}) begin
            rs1_data = regs_r[rs1_addr];
        end else begin
            rs1_data = {DATA_WIDTH{1'b0}};
        end
    end

    // Read port 2, forcing zero for x0 regardless of array contents.
    always_comb begin
        rs2_data = {DATA_WIDTH{1'b0}};
        if (rs2_addr != {AW{1'b0}}) begin
            rs2_data = regs_r[rs2_addr];
        end else begin
            rs2_data = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/alu_decode.sv
// Decode / operand-fetch stage for RV32I OP and OP-IMM feeding the ALU.
// One-entry output register with valid/ready on both sides; write-back
// arriving in the accept cycle is forwarded into the captured operands.
module alu_decode
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic                  wb_en,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] lhs,
    output logic [DATA_WIDTH-1:0] rhs,
    output logic [2:0]            operation,
    output logic [6:0]            metadata,
    output logic [4:0]            rd,
    output logic                  illegal
);

    logic [6:0]            opcode_s;
    logic [4:0]            rd_s;
    logic [4:0]            rs1_s;
    logic [4:0]            rs2_s;
    funct3_e               funct3_s;
    logic [6:0]            funct7_s;
    logic [DATA_WIDTH-1:0] rf_rs1_s;
    logic [DATA_WIDTH-1:0] rf_rs2_s;
    logic [DATA_WIDTH-1:0] rs1_val_s;
    logic [DATA_WIDTH-1:0] rs2_val_s;
    logic                  legal_s;
    logic                  accept_s;
    decode_bundle_t        dec_s;
    decode_bundle_t        bundle_r;
    logic                  out_valid_r;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign funct3_s = funct3_e'(instr[14:12]);
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];
    assign funct7_s = instr[31:25];

    register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_s),
        .rs2_addr (rs2_s),
        .rs1_data (rf_rs1_s),
        .rs2_data (rf_rs2_s),
        .we       (wb_en),
        .waddr    (wb_rd),
        .wdata    (wb_data)
    );

    // Forward same-cycle write-back so the captured operand is never stale.
    always_comb begin
        rs1_val_s = rf_rs1_s;
        rs2_val_s = rf_rs2_s;
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_rs1_s;
        end
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_rs2_s;
        end
    end

    // Form the bundle; anything illegal collapses to a zeroed marker so the
    // ALU never sees an undefined funct3/funct7 pair.
    always_comb begin
        legal_s         = 1'b0;
        dec_s           = '0;
        dec_s.lhs       = rs1_val_s;
        dec_s.operation = funct3_s;
        dec_s.rd        = rd_s;
        case (opcode_s)
            OPCODE_OP: begin
                dec_s.metadata = funct7_s;
                // ALU shifts by the full rhs, so register shifts are masked.
                if ((funct3_s == F3_SLL) || (funct3_s == F3_SR)) begin
                    dec_s.rhs = {{(XLEN-5){1'b0}}, rs2_val_s[4:0]};
                end else begin
                    dec_s.rhs = rs2_val_s;
                end
                if (funct7_s == FUNCT7_BASE) begin
                    legal_s = 1'b1;
                end else if ((funct7_s == FUNCT7_ALT) &&
                             ((funct3_s == F3_ADD) || (funct3_s == F3_SR))) begin
                    legal_s = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPCODE_OP_IMM: begin
                case (funct3_s)
                    F3_SLL: begin
                        dec_s.rhs      = {{(XLEN-5){1'b0}}, instr[24:20]};
                        dec_s.metadata = funct7_s;
                        legal_s        = (funct7_s == FUNCT7_BASE);
                    end
                    F3_SR: begin
                        dec_s.rhs      = {{(XLEN-5){1'b0}}, instr[24:20]};
                        dec_s.metadata = funct7_s;
                        legal_s        = (funct7_s == FUNCT7_BASE) ||
                                         (funct7_s == FUNCT7_ALT);
                    end
                    default: begin
                        // Upper immediate bits are not a funct7: keep metadata 0.
                        dec_s.rhs      = {{(XLEN-12){instr[31]}}, instr[31:20]};
                        dec_s.metadata = 7'h00;
                        legal_s        = 1'b1;
                    end
                endcase
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        if (!legal_s) begin
            dec_s         = '0;
            dec_s.illegal = 1'b1;
        end else begin
            dec_s.illegal = 1'b0;
        end
    end

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // One-entry output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            bundle_r    <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            bundle_r    <= dec_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign illegal   = bundle_r.illegal;
    assign lhs       = bundle_r.lhs;
    assign rhs       = bundle_r.rhs;
    assign operation = bundle_r.operation;
    assign metadata  = bundle_r.metadata;
    assign rd        = bundle_r.rd;

endmodule

// File: tb/tb_alu_decode.sv
// Self-checking bench for alu_decode: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_alu_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [2:0]  operation;
    logic [6:0]  metadata;
    logic [4:0]  rd;
    logic        illegal;

    always #5 clk = ~clk;

    alu_decode #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lhs       (lhs),
        .rhs       (rhs),
        .operation (operation),
        .metadata  (metadata),
        .rd        (rd),
        .illegal   (illegal)
    );

    typedef struct {
        logic        ill;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [2:0]  op;
        logic [6:0]  meta;
        logic [4:0]  rd;
    } exp_t;

    logic [31:0] m_regs [32];
    logic        m_valid;
    exp_t        m_b;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the ISA rules, using the model's
    // register contents (already updated with this cycle's write-back).
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t        r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic        ok;
        logic        is_shift;
        opc      = ins[6:0];
        f3       = ins[14:12];
        f7       = ins[31:25];
        a        = m_regs[ins[19:15]];
        b        = m_regs[ins[24:20]];
        is_shift = (f3 == 3'd1) || (f3 == 3'd5);
        ok       = 1'b0;
        r.ill    = 1'b0;
        r.lhs    = a;
        r.op     = f3;
        r.rd     = ins[11:7];
        r.rhs    = 32'h0;
        r.meta   = 7'h00;
        if (opc == 7'h33) begin
            ok     = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            r.rhs  = is_shift ? (b % 32'd32) : b;
            r.meta = f7;
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else                 ok = 1'b1;
            r.rhs  = is_shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
            r.meta = is_shift ? f7 : 7'h00;
        end
        if (!ok) begin
            r = '{ill: 1'b1, lhs: 32'h0, rhs: 32'h0, op: 3'd0, meta: 7'h00, rd: 5'd0};
        end
        return r;
    endfunction

    task automatic check_out();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("illegal",   32'(illegal),   32'(m_b.ill));
        check("lhs",       lhs,            m_b.lhs);
        check("rhs",       rhs,            m_b.rhs);
        check("operation", 32'(operation), 32'(m_b.op));
        check("metadata",  32'(metadata),  32'(m_b.meta));
        check("rd",        32'(rd),        32'(m_b.rd));
    endtask

    // Advance one clock with the currently driven inputs and update the model.
    task automatic cycle();
        logic acc;
        #1;
        acc = in_valid && (!m_valid || out_ready);
        if (rst) check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_valid = 1'b0;
            m_b = '{ill: 1'b0, lhs: 32'h0, rhs: 32'h0, op: 3'd0, meta: 7'h00, rd: 5'd0};
        end else begin
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            if (acc) begin
                m_b     = ref_decode(instr);
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_out();
    endtask

    initial begin
        logic [6:0] f7;
        logic [6:0] opc;
        m_valid   = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        wb_en     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'h0;
        out_ready = 1'b1;
        cycle();
        cycle();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_lhs", lhs, 32'h0);

        // ADDI x1,x0,-5
        rst = 1'b1; in_valid = 1'b1; instr = 32'hFFB00093;
        cycle();
        check("addi_valid", 32'(out_valid), 32'h1);
        check("addi_rhs", rhs, 32'hFFFFFFFB);
        check("addi_meta", 32'(metadata), 32'h0);
        check("addi_rd", 32'(rd), 32'h1);
        check("addi_ill", 32'(illegal), 32'h0);

        // x1 <= 0x80000000, then SRAI x2,x1,3
        in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h80000000;
        cycle();
        wb_en = 1'b0; in_valid = 1'b1; instr = 32'h4030D113;
        cycle();
        check("srai_lhs", lhs, 32'h80000000);
        check("srai_rhs", rhs, 32'h3);
        check("srai_op", 32'(operation), 32'h5);
        check("srai_meta", 32'(metadata), 32'h20);

        // SUB x4,x3,x3 with x3 written in the same cycle
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234; instr = 32'h40318233;
        cycle();
        check("byp_lhs", lhs, 32'h1234);
        check("byp_rhs", rhs, 32'h1234);
        check("byp_meta", 32'(metadata), 32'h20);
        wb_en = 1'b0; instr = 32'h000182B3;
        cycle();
        check("x3_later", lhs, 32'h1234);

        // SLL with x6 = 0x25 masks to 5
        in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h25;
        cycle();
        wb_en = 1'b0; in_valid = 1'b1; instr = 32'h006013B3;
        cycle();
        check("sll_rhs", rhs, 32'h5);

        // Illegal opcode 0x03
        instr = 32'h12345603;
        cycle();
        check("ill_flag", 32'(illegal), 32'h1);
        check("ill_lhs", lhs, 32'h0);
        check("ill_rd", 32'(rd), 32'h0);

        // x0 write ignored
        in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        cycle();
        wb_en = 1'b0; in_valid = 1'b1; instr = 32'h00000433;
        cycle();
        check("x0_lhs", lhs, 32'h0);

        // Backpressure: hold ADDI x9, then release B (x10), C (x11)
        instr = 32'h00100493;
        cycle();
        out_ready = 1'b0; instr = 32'h00100513;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_hold_rd", 32'(rd), 32'h9);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_rel_b", 32'(rd), 32'd10);
        instr = 32'h00100593;
        cycle();
        check("bp_rel_c", 32'(rd), 32'd11);
        in_valid = 1'b0;
        cycle();
        check("drain_valid", 32'(out_valid), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1:    opc = 7'h33;
                2:       opc = 7'h13;
                default: opc = 7'($urandom);
            endcase
            instr     = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         3'($urandom), 5'($urandom), opc};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            cycle();
        end

        // Reset while stalled discards the held bundle and clears registers
        wb_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100613;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("rst_stall_valid", 32'(out_valid), 32'h0);
        rst = 1'b1; out_ready = 1'b1; instr = 32'h000182B3;
        cycle();
        check("rst_regs_clear", lhs, 32'h0);
        check("rst_after_valid", 32'(out_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
